mem_store_buffer: RTL

MEM_STORE_BUFFER -- requirements
Module: mem_store_buffer

---
 rtl/mem_store_buffer_if.sv | 29 ++
 rtl/mem_store_buffer.sv | 89 ++++++++
 2 files changed

// File: rtl/mem_store_buffer_if.sv
// Bundle of MEM-stage store/load signals and data-memory port for the store buffer.
// The slave modport is the buffer; the master modport is the pipeline and memory side.
interface mem_store_buffer_if;
   logic        st_valid;
   logic [31:0] st_pc;
   logic [31:0] st_addr;
   logic [31:0] st_data;
   logic        stall;
   logic        ld_valid;
   logic [31:0] ld_addr;
   logic [31:0] ld_data;
   logic        dm_we;
   logic [31:0] dm_pc;
   logic [31:0] dm_addr;
   logic [31:0] dm_din;
   logic [31:0] dm_dout;
   logic        empty;
   logic [4:0]  count;

   modport master (
      output st_valid, st_pc, st_addr, st_data, ld_valid, ld_addr, dm_dout,
      input  stall, ld_data, dm_we, dm_pc, dm_addr, dm_din, empty, count
   );

   modport slave (
      input  st_valid, st_pc, st_addr, st_data, ld_valid, ld_addr, dm_dout,
      output stall, ld_data, dm_we, dm_pc, dm_addr, dm_din, empty, count
   );
endinterface

// File: rtl/mem_store_buffer.sv
// In-order store buffer between MEM and data memory: drains one store per idle
// memory cycle and forwards the youngest matching store to word loads.
module mem_store_buffer #(
   parameter int DEPTH = 4
) (
   input logic              clk,
   input logic              reset,
   mem_store_buffer_if.slave bus
);
   localparam int PW = $clog2(DEPTH);
   typedef logic [PW-1:0] ptr_t;

   logic [31:0] pc_q   [DEPTH];
   logic [31:0] addr_q [DEPTH];
   logic [31:0] data_q [DEPTH];

   ptr_t        head_q, head_d;
   ptr_t        tail_q, tail_d;
   logic [4:0]  count_q, count_d;

   logic        full;
   logic        enq;
   logic        deq;
   logic        fwd_hit;
   logic [31:0] fwd_data;
   ptr_t        idx;

   assign full = (count_q == 5'(DEPTH));
   // A full buffer rejects the store even if the head drains this cycle.
   assign enq  = !reset && bus.st_valid && !full;
   assign deq  = !reset && (count_q != 5'd0) && !bus.ld_valid;

   assign bus.stall   = !reset && bus.st_valid && full;
   assign bus.dm_we   = deq;
   assign bus.dm_pc   = pc_q[head_q];
   assign bus.dm_din  = data_q[head_q];
   assign bus.dm_addr = bus.ld_valid        ? bus.ld_addr :
                        (count_q != 5'd0)   ? addr_q[head_q] : 32'd0;
   assign bus.empty   = (count_q == 5'd0);
   assign bus.count   = count_q;
   assign bus.ld_data = (!reset && fwd_hit) ? fwd_data : bus.dm_dout;

   // Walk oldest to youngest so the last match wins.
   always_comb begin
      fwd_hit  = 1'b0;
      fwd_data = 32'd0;
      idx      = '0;
      for (int k = 0; k < DEPTH; k++) begin
         idx = head_q + ptr_t'(k);
         if ((5'(k) < count_q) && (addr_q[idx][13:2] == bus.ld_addr[13:2])) begin
            fwd_hit  = 1'b1;
            fwd_data = data_q[idx];
         end
      end
   end

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (deq) head_d = head_q + ptr_t'(1);
      if (enq) tail_d = tail_q + ptr_t'(1);
      unique case ({enq, deq})
         2'b10:   count_d = count_q + 5'd1;
         2'b01:   count_d = count_q - 5'd1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= 5'd0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (enq) begin
         pc_q[tail_q]   <= bus.st_pc;
         addr_q[tail_q] <= bus.st_addr;
         data_q[tail_q] <= bus.st_data;
      end
   end
endmodule
